// File: rtl/iq_fifo_drain.sv
// Drains the interpolator's I/Q output FIFO pair into a dual sample memory.
// Pops both FIFOs in lockstep and writes each pair at consecutive addresses.
module iq_fifo_drain #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] len_i,
    input  logic                  hold_i,
    input  logic                  empty_i,
    input  logic [DATA_WIDTH-1:0] data_I_i,
    input  logic [DATA_WIDTH-1:0] data_Q_i,
    output logic                  re_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_I_o,
    output logic [DATA_WIDTH-1:0] data_Q_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] issued;
    logic [ADDR_WIDTH-1:0] written;
    logic                  rd_valid;
    logic                  last_pop;
    logic                  last_write;

    // Hold only stops new pops; anything already popped still reaches memory.
    assign re_o       = (state == RUN) && !empty_i && !hold_i && (issued < len_q);
    assign last_pop   = re_o && ((issued + ONE) == len_q);
    assign last_write = we_o && ((written + ONE) == len_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            written  <= '0;
            rd_valid <= 1'b0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            data_I_o <= '0;
            data_Q_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            rd_valid <= re_o;
            we_o     <= rd_valid;
            if (rd_valid) begin
                data_I_o <= data_I_i;
                data_Q_o <= data_Q_i;
            end
            if (re_o) begin
                issued <= issued + ONE;
            end
            if (we_o) begin
                written <= written + ONE;
                addr_o  <= addr_o + ONE;
            end

            case (state)
                IDLE: begin
                    if (start_i) begin
                        len_q   <= len_i;
                        issued  <= '0;
                        written <= '0;
                        addr_o  <= '0;
                        busy_o  <= 1'b1;
                        state   <= (len_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (last_pop) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (last_write) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    // A zero-length run arrives here without done_o set; pulse it first.
                    if (done_o) begin
                        done_o <= 1'b0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_fifo_drain.sv
// Directed bench for iq_fifo_drain: a behavioural FIFO pair feeds the drain and
// every memory write is logged, then compared against hand-derived expectations.
`timescale 1ns/1ps
module tb_iq_fifo_drain;

    localparam int DW = 12;
    localparam int AW = 20;
    localparam int LOG_DEPTH = 256;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic [AW-1:0] len_i;
    logic          hold_i;
    logic          empty_i = 1'b1;
    logic [DW-1:0] data_I_i = '0;
    logic [DW-1:0] data_Q_i = '0;
    logic          re_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_I_o;
    logic [DW-1:0] data_Q_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int src_base = 0;
    int src_len = 0;
    int feed_every = 0;
    int fifo_gen = 0;
    int seen_gen = 0;
    int pushed = 0;
    int popped = 0;
    int feed_cnt = 0;
    logic pop_now = 1'b0;

    int re_total = 0;
    int empty_viol = 0;
    int hold_re = 0;
    int first_re_cyc = -1;
    int last_re_cyc = -1;

    int wr_total = 0;
    int done_total = 0;
    int busy_viol = 0;
    int last_we_cyc = -1;
    int done_cyc = -1;
    logic [AW-1:0] log_addr [LOG_DEPTH];
    logic [DW-1:0] log_I    [LOG_DEPTH];
    logic [DW-1:0] log_Q    [LOG_DEPTH];

    iq_fifo_drain #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start_i  (start_i),
        .len_i    (len_i),
        .hold_i   (hold_i),
        .empty_i  (empty_i),
        .data_I_i (data_I_i),
        .data_Q_i (data_Q_i),
        .re_o     (re_o),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .data_I_o (data_I_o),
        .data_Q_o (data_Q_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO pair: pops seen at a rising edge return data 1 ns later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        pop_now = re_o;
        if (re_o) begin
            re_total++;
            if (first_re_cyc < 0) first_re_cyc = cyc - 1;
            last_re_cyc = cyc - 1;
            if (empty_i) empty_viol++;
            if (hold_i) hold_re++;
        end
        #1;
        if (seen_gen != fifo_gen) begin
            seen_gen = fifo_gen;
            pushed = 0;
            popped = 0;
            feed_cnt = 0;
            first_re_cyc = -1;
            pop_now = 1'b0;
        end
        if (pop_now) begin
            data_I_i = DW'(src_base + popped);
            data_Q_i = DW'(-(src_base + popped));
            popped++;
        end
        if (feed_every == 0) begin
            pushed = src_len;
        end else if (pushed < src_len) begin
            feed_cnt++;
            if (feed_cnt >= feed_every) begin
                pushed++;
                feed_cnt = 0;
            end
        end
        empty_i = (pushed <= popped);
    end

    always @(negedge clk) begin
        if (we_o) begin
            if (wr_total < LOG_DEPTH) begin
                log_addr[wr_total] = addr_o;
                log_I[wr_total]    = data_I_o;
                log_Q[wr_total]    = data_Q_o;
            end
            wr_total++;
            last_we_cyc = cyc;
            if (!busy_o) busy_viol++;
        end
        if (done_o) begin
            done_total++;
            done_cyc = cyc;
            if (!busy_o) busy_viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic loadFifo(input int base, input int len, input int every);
        src_base   = base;
        src_len    = len;
        feed_every = every;
        fifo_gen++;
        tick();
        tick();
    endtask

    task automatic applyStimulus(input int len, output int s_cyc);
        len_i   = AW'(len);
        start_i = 1'b1;
        s_cyc   = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int d_cyc);
        logic found;
        found = 1'b0;
        d_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_o) begin
                found = 1'b1;
                d_cyc = cyc;
                break;
            end
            tick();
        end
        checkOutput("done_seen", 64'(found), 64'd1);
    endtask

    task automatic checkRun(input int len, input int base, input int wbase);
        logic [DW-1:0] exp_i;
        logic [DW-1:0] exp_q;
        checkOutput("wr_count", 64'(wr_total - wbase), 64'(len));
        for (int i = 0; i < len; i++) begin
            exp_i = DW'(base + i);
            exp_q = DW'(-(base + i));
            checkOutput("wr_addr", 64'(log_addr[wbase + i]), 64'(i));
            checkOutput("wr_data_I", 64'(log_I[wbase + i]), 64'(exp_i));
            checkOutput("wr_data_Q", 64'(log_Q[wbase + i]), 64'(exp_q));
        end
    endtask

    initial begin
        int s_cyc, s2_cyc, d_cyc;
        int re0, wr0, done0, ev0, hr0, bv0;

        rstn    = 1'b0;
        start_i = 1'b0;
        len_i   = '0;
        hold_i  = 1'b0;
        repeat (3) tick();
        checkOutput("reset_outputs",
                    64'({re_o, we_o, busy_o, done_o, addr_o, data_I_o, data_Q_o}), 64'd0);
        rstn = 1'b1;
        tick();

        $display("[TB] streaming run, len 8");
        loadFifo(1, 8, 0);
        re0 = re_total; wr0 = wr_total; done0 = done_total; bv0 = busy_viol;
        applyStimulus(8, s_cyc);
        waitDone(200, d_cyc);
        checkOutput("stream_first_re", 64'(first_re_cyc), 64'(s_cyc + 1));
        checkOutput("stream_last_re", 64'(last_re_cyc), 64'(s_cyc + 8));
        checkOutput("stream_re_count", 64'(re_total - re0), 64'd8);
        checkRun(8, 1, wr0);
        checkOutput("stream_last_we", 64'(last_we_cyc), 64'(s_cyc + 10));
        checkOutput("stream_done_cyc", 64'(d_cyc), 64'(s_cyc + 11));
        tick();
        checkOutput("stream_busy_fall", 64'(busy_o), 64'd0);
        tick();
        checkOutput("stream_done_count", 64'(done_total - done0), 64'd1);
        checkOutput("stream_busy_held", 64'(busy_viol - bv0), 64'd0);

        $display("[TB] starved source, len 5");
        loadFifo(64, 5, 4);
        re0 = re_total; wr0 = wr_total; done0 = done_total; ev0 = empty_viol;
        applyStimulus(5, s_cyc);
        waitDone(300, d_cyc);
        tick();
        checkOutput("starve_re_count", 64'(re_total - re0), 64'd5);
        checkOutput("starve_pop_empty", 64'(empty_viol - ev0), 64'd0);
        checkRun(5, 64, wr0);
        checkOutput("starve_done_count", 64'(done_total - done0), 64'd1);

        $display("[TB] hold mid-run, len 16");
        loadFifo(256, 16, 0);
        re0 = re_total; wr0 = wr_total; done0 = done_total; hr0 = hold_re;
        applyStimulus(16, s_cyc);
        for (int i = 0; i < 100 && (re_total - re0) < 6; i++) tick();
        checkOutput("hold_reach_6", 64'(re_total - re0), 64'd6);
        hold_i = 1'b1;
        repeat (20) tick();
        checkOutput("hold_re_frozen", 64'(re_total - re0), 64'd6);
        checkOutput("hold_inflight_wr", 64'(wr_total - wr0), 64'd6);
        checkOutput("hold_re_during", 64'(hold_re - hr0), 64'd0);
        hold_i = 1'b0;
        waitDone(200, d_cyc);
        tick();
        tick();
        checkRun(16, 256, wr0);
        checkOutput("hold_done_count", 64'(done_total - done0), 64'd1);

        $display("[TB] zero length");
        re0 = re_total; wr0 = wr_total;
        applyStimulus(0, s_cyc);
        waitDone(20, d_cyc);
        checkOutput("zero_done_cyc", 64'(d_cyc), 64'(s_cyc + 2));
        tick();
        checkOutput("zero_re_count", 64'(re_total - re0), 64'd0);
        checkOutput("zero_wr_count", 64'(wr_total - wr0), 64'd0);

        $display("[TB] start ignored during run, len 10");
        loadFifo(512, 10, 0);
        wr0 = wr_total; done0 = done_total;
        applyStimulus(10, s_cyc);
        tick();
        tick();
        len_i   = AW'(3);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        waitDone(200, d_cyc);
        tick();
        tick();
        checkRun(10, 512, wr0);
        checkOutput("ignore_done_count", 64'(done_total - done0), 64'd1);

        $display("[TB] reset mid-run");
        loadFifo(768, 10, 0);
        wr0 = wr_total; done0 = done_total;
        applyStimulus(10, s_cyc);
        for (int i = 0; i < 100 && (wr_total - wr0) < 4; i++) tick();
        checkOutput("rst_reach_4", 64'(wr_total - wr0), 64'd4);
        rstn = 1'b0;
        #1;
        checkOutput("rst_outputs_zero",
                    64'({re_o, we_o, busy_o, done_o, addr_o, data_I_o, data_Q_o}), 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        checkOutput("rst_no_done", 64'(done_total - done0), 64'd0);
        checkOutput("rst_idle_busy", 64'(busy_o), 64'd0);
        loadFifo(1024, 2, 0);
        wr0 = wr_total; done0 = done_total;
        applyStimulus(2, s_cyc);
        waitDone(100, d_cyc);
        tick();
        checkRun(2, 1024, wr0);
        checkOutput("rst_rerun_done", 64'(done_total - done0), 64'd1);

        $display("[TB] back-to-back runs");
        loadFifo(1280, 3, 0);
        wr0 = wr_total; done0 = done_total;
        applyStimulus(3, s_cyc);
        waitDone(100, d_cyc);
        checkRun(3, 1280, wr0);
        wr0 = wr_total;
        src_base   = 1536;
        src_len    = 4;
        feed_every = 0;
        fifo_gen++;
        len_i   = AW'(4);
        start_i = 1'b1;
        tick();
        s2_cyc = cyc;
        tick();
        start_i = 1'b0;
        waitDone(100, d_cyc);
        checkOutput("b2b_first_re", 64'(first_re_cyc), 64'(s2_cyc + 1));
        tick();
        checkRun(4, 1536, wr0);
        checkOutput("b2b_done_count", 64'(done_total - done0), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
